// File: rtl/timer_counter.sv
// timer_counter: memory-mapped 32-bit down-counter timer with one-shot and auto-reload IRQ modes
// Ports: clk, reset (sync, active-high); Addr selects 0=CTRL 1=PRESET 2=COUNT 3=zero;
//        WE/DIn write CTRL/PRESET; DOut is combinational read data; IRQ feeds cp0 HWInt[2].
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] DIn,
    output logic [31:0] DOut,
    output logic        IRQ
);
    typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
    state_t state, state_n;
    logic [3:0] ctrl, ctrl_n;
    logic [31:0] preset, count, count_n;
    logic flag, flag_n;
    logic wr_ctrl, wr_preset;
    assign wr_ctrl = WE && Addr == 2'd0;
    assign wr_preset = WE && Addr == 2'd1;
    assign DOut = Addr == 2'd0 ? {28'b0, ctrl} : Addr == 2'd1 ? preset : Addr == 2'd2 ? count : '0;
    assign IRQ = flag & ctrl[3];
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ctrl <= '0;
            preset <= '0;
            count <= '0;
            flag <= 1'b0;
        end else begin
            state <= state_n;
            ctrl <= ctrl_n;
            preset <= wr_preset ? DIn : preset;
            count <= count_n;
            flag <= flag_n;
        end
    end
    // The FSM sets irq_flag after the software clear so a same-edge set wins,
    // and the software CTRL write is applied last so it beats the one-shot En clear.
    always_comb begin
        state_n = state;
        ctrl_n = ctrl;
        count_n = count;
        flag_n = (wr_ctrl || wr_preset) ? 1'b0 : flag;
        case (state)
            IDLE: state_n = ctrl[0] ? LOAD : IDLE;
            LOAD: begin
                count_n = preset;
                flag_n = 1'b0;
                state_n = CNT;
            end
            CNT: begin
                if (!ctrl[0]) state_n = IDLE;
                else if (count > 32'd1) count_n = count - 32'd1;
                else begin
                    count_n = '0;
                    flag_n = 1'b1;
                    state_n = INT;
                end
            end
            INT: begin
                state_n = IDLE;
                if (ctrl[2:1] == 2'd1) flag_n = 1'b0;
                else ctrl_n[0] = 1'b0;
            end
        endcase
        if (wr_ctrl) ctrl_n = DIn[3:0];
    end
endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: directed self-checking bench for timer_counter
module tb_timer_counter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [1:0] Addr = '0;
    logic WE = 1'b0;
    logic [31:0] DIn = '0;
    logic [31:0] DOut;
    logic IRQ;
    int checks = 0;
    int errors = 0;

    timer_counter dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .DIn(DIn), .DOut(DOut), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        Addr = a;
        DIn = d;
        WE = 1'b1;
        tick();
        WE = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = DOut;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            rd(a[1:0], d);
            checks++;
            if (d !== 32'd0) begin errors++; $display("FAIL reset_reg%0d got %h want 0", a, d); end
        end
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL reset_irq got %b want 0", IRQ); end
    endtask

    task automatic test_oneshot();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'h9);
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k >= 2) begin
                rd(2'd2, d);
                checks++;
                if (d !== 32'(5 - k)) begin errors++; $display("FAIL oneshot_count t+%0d got %0d want %0d", k, d, 5 - k); end
            end
            checks++;
            if (IRQ !== (k == 5)) begin errors++; $display("FAIL oneshot_irq t+%0d got %b want %b", k, IRQ, k == 5); end
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (IRQ !== 1'b1) begin errors++; $display("FAIL oneshot_irq_held got %b want 1", IRQ); end
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h8) begin errors++; $display("FAIL oneshot_en_clear got %h want 8", d); end
        wr(2'd0, 32'h0);
        checks++;
        if (IRQ !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear got %b want 0", IRQ); end
    endtask

    task automatic test_reload();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if (IRQ !== (k == 4 || k == 9 || k == 14)) begin
                errors++; $display("FAIL reload_irq t+%0d got %b want %b", k, IRQ, k == 4 || k == 9 || k == 14);
            end
            if (k == 7) begin
                rd(2'd2, d);
                checks++;
                if (d !== 32'd2) begin errors++; $display("FAIL reload_count got %0d want 2", d); end
            end
        end
    endtask

    task automatic test_mask();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (IRQ !== 1'b0) begin errors++; $display("FAIL mask_irq t+%0d got %b want 0", k, IRQ); end
        end
        rd(2'd0, d);
        checks++;
        if (d !== 32'h0) begin errors++; $display("FAIL mask_en_clear got %h want 0", d); end
        do_reset();
        wr(2'd1, 32'd1);
        wr(2'd0, 32'h1);
        tick();
        tick();
        wr(2'd0, 32'h8);
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL mask_unmask_irq got %b want 1", IRQ); end
        tick();
        tick();
        checks++;
        if (IRQ !== 1'b1) begin errors++; $display("FAIL mask_unmask_held got %b want 1", IRQ); end
    endtask

    task automatic test_preset_zero();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd0);
        wr(2'd0, 32'h9);
        tick();
        tick();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd0 || IRQ !== 1'b0) begin errors++; $display("FAIL zero_pre count %0d irq %b want 0 0", d, IRQ); end
        wr(2'd2, 32'h1234);
        rd(2'd2, d);
        checks++;
        if (d !== 32'd0 || IRQ !== 1'b1) begin errors++; $display("FAIL zero_int count %0d irq %b want 0 1", d, IRQ); end
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3, d);
        checks++;
        if (d !== 32'd0) begin errors++; $display("FAIL addr3_read got %h want 0", d); end
    endtask

    task automatic test_freeze();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h1);
        tick();
        tick();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd10) begin errors++; $display("FAIL freeze_load got %0d want 10", d); end
        wr(2'd1, 32'd99);
        rd(2'd2, d);
        checks++;
        if (d !== 32'd9) begin errors++; $display("FAIL freeze_preset_midcount got %0d want 9", d); end
        wr(2'd2, 32'h1234);
        rd(2'd2, d);
        checks++;
        if (d !== 32'd8) begin errors++; $display("FAIL freeze_count_ro got %0d want 8", d); end
        tick();
        wr(2'd0, 32'h0);
        for (int k = 0; k < 4; k++) begin
            tick();
            rd(2'd2, d);
            checks++;
            if (d !== 32'd6) begin errors++; $display("FAIL freeze_hold got %0d want 6", d); end
        end
        wr(2'd0, 32'h1);
        tick();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd6) begin errors++; $display("FAIL freeze_idle got %0d want 6", d); end
        tick();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd99) begin errors++; $display("FAIL freeze_reload got %0d want 99", d); end
    endtask

    task automatic test_reset_midcount();
        logic [31:0] d;
        do_reset();
        wr(2'd1, 32'd6);
        wr(2'd0, 32'hB);
        for (int k = 0; k < 4; k++) tick();
        rd(2'd2, d);
        checks++;
        if (d !== 32'd4) begin errors++; $display("FAIL midreset_pre got %0d want 4", d); end
        do_reset();
        for (int k = 0; k < 6; k++) begin
            tick();
            for (int a = 0; a < 3; a++) begin
                rd(a[1:0], d);
                checks++;
                if (d !== 32'd0) begin errors++; $display("FAIL midreset_reg%0d got %h want 0", a, d); end
            end
            checks++;
            if (IRQ !== 1'b0) begin errors++; $display("FAIL midreset_irq got %b want 0", IRQ); end
        end
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_reload();
        test_mask();
        test_preset_zero();
        test_freeze();
        test_reset_midcount();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
